// File: rtl/sync_gate_seq_if.sv
`default_nettype none
// ============================================================================
// sync_gate_seq_if : request/status bundle for the Sync/Gate/Done sequencer
// Revision 1.0
// ============================================================================
interface sync_gate_seq_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             hold;
  logic             abort;
  logic             sync;
  logic             gate;
  logic             done;
  logic             busy;
  logic [3:0]       state;
  logic [CNT_W-1:0] wc;
  logic             wc0;
  logic             aborted;

  modport master (
    output start, len, hold, abort,
    input  sync, gate, done, busy, state, wc, wc0, aborted
  );

  modport slave (
    input  start, len, hold, abort,
    output sync, gate, done, busy, state, wc, wc0, aborted
  );
endinterface
`default_nettype wire

// File: rtl/sync_gate_seq.sv
`default_nettype none
// ============================================================================
// sync_gate_seq : Sync -> Gate (counted beats) -> Drain -> Done sequencer
// Revision 1.0
// ============================================================================
module sync_gate_seq #(
  parameter int CNT_W        = 8,
  parameter int SYNC_CYCLES  = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  sync_gate_seq_if.slave    bus
);

  localparam int PH_MAX = (SYNC_CYCLES > DRAIN_CYCLES) ? SYNC_CYCLES : DRAIN_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] C_SYNC_LOAD  = PH_W'(SYNC_CYCLES - 1);
  localparam logic [PH_W-1:0] C_DRAIN_LOAD = PH_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  // State encoding is the one-hot vector presented on the state output.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0000,
    ST_SYNC  = 4'b0001,
    ST_GATE  = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CNT_W-1:0] wc_q, wc_d;
  logic             aborted_q, aborted_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ph_q      <= '0;
      wc_q      <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      wc_q      <= wc_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    wc_d      = wc_q;
    aborted_d = aborted_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          aborted_d = 1'b0;
          wc_d      = bus.len;
          if (bus.len != '0) begin
            ph_d    = C_SYNC_LOAD;
            state_d = ST_SYNC;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SYNC: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (ph_q == '0) begin
          state_d = ST_GATE;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      ST_GATE: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (!bus.hold) begin
          if (wc_q != '0) begin
            wc_d = wc_q - 1'b1;
          end
          // Last beat (or a degenerate zero count) ends the gate window.
          if (wc_q <= CNT_W'(1)) begin
            ph_d    = C_DRAIN_LOAD;
            state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (ph_q == '0) begin
          state_d = ST_DONE;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.sync    = state_q[0];
  assign bus.gate    = state_q[1];
  assign bus.done    = state_q[3];
  assign bus.busy    = |state_q;
  assign bus.state   = state_q;
  assign bus.wc      = wc_q;
  assign bus.wc0     = (wc_q == '0);
  assign bus.aborted = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_gate_seq.sv
`default_nettype none
// ============================================================================
// tb_sync_gate_seq : directed self-checking bench for sync_gate_seq
// Revision 1.0
// ============================================================================
module tb_sync_gate_seq;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  sync_gate_seq_if #(.CNT_W(CNT_W)) bus ();

  sync_gate_seq #(
    .CNT_W        (CNT_W),
    .SYNC_CYCLES  (4),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected one-hot state for cycle k of a transfer started at cycle 0.
  function automatic logic [3:0] exp_state(int k, int s_end, int g_end, int d_end);
    if (k <= 0)          return 4'b0000;
    if (k <= s_end)      return 4'b0001;
    if (k <= g_end)      return 4'b0010;
    if (k <= d_end)      return 4'b0100;
    if (k == d_end + 1)  return 4'b1000;
    return 4'b0000;
  endfunction

  // Compares the full output set; sync/gate/done/busy follow their state bits.
  task automatic check_cycle(input string tag, input int k, input logic [3:0] st,
                             input int wc, input logic ab);
    logic [9:0] got, exp;
    got = {bus.sync, bus.gate, bus.done, bus.busy, bus.state, bus.wc0, bus.aborted};
    exp = {st[0], st[1], st[3], (st != 4'b0000), st, (wc == 0), ab};
    chk($sformatf("%s_ctl@%0d", tag, k), {22'd0, got}, {22'd0, exp});
    chk($sformatf("%s_wc@%0d", tag, k), {24'd0, bus.wc}, wc);
  endtask

  function automatic int wc_len5(int k);
    if (k <= 5) return 5;
    if (k <= 9) return 10 - k;
    return 0;
  endfunction

  // len=5 transfer from IDLE, no hold/abort; ends at cycle 13 (IDLE).
  task automatic plain5(input string tag);
    bus.start = 1'b1;
    bus.len   = 8'd5;
    cyc();
    bus.start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      check_cycle(tag, k, exp_state(k, 4, 9, 11), wc_len5(k), 1'b0);
      if (k < 13) cyc();
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.len   = '0;
    bus.hold  = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    check_cycle("reset", 0, 4'b0000, 0, 1'b0);

    // Basic len=5 transfer.
    plain5("t1");

    // Hold during cycles 6-7 stretches gate to 5..11, done at 14.
    bus.start = 1'b1;
    bus.len   = 8'd5;
    cyc();
    bus.start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      int w;
      bus.hold = (k == 6 || k == 7);
      w = (k <= 5) ? 5 : (k <= 8) ? 4 : (k <= 11) ? 12 - k : 0;
      check_cycle("hold", k, exp_state(k, 4, 11, 13), w, 1'b0);
      if (k < 15) cyc();
    end
    bus.hold = 1'b0;

    // len=0 goes straight to DONE.
    bus.start = 1'b1;
    bus.len   = 8'd0;
    cyc();
    bus.start = 1'b0;
    check_cycle("len0", 1, 4'b1000, 0, 1'b0);
    cyc();
    check_cycle("len0", 2, 4'b0000, 0, 1'b0);

    // Abort at cycle 7 in GATE: done at 8, wc frozen at 3, IDLE at 9.
    bus.start = 1'b1;
    bus.len   = 8'd5;
    cyc();
    bus.start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      logic [3:0] st;
      bus.abort = (k == 7);
      st = (k <= 7) ? exp_state(k, 4, 9, 11) : (k == 8) ? 4'b1000 : 4'b0000;
      check_cycle("abort", k, st, (k <= 7) ? wc_len5(k) : 3, (k >= 8));
      if (k < 9) cyc();
    end
    bus.abort = 1'b0;
    plain5("after_abort");

    // Reset mid-transfer at cycle 6.
    bus.start = 1'b1;
    bus.len   = 8'd5;
    cyc();
    bus.start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check_cycle("rstmid", k, exp_state(k, 4, 9, 11), wc_len5(k), 1'b0);
      if (k < 6) cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_cycle("rstmid", 7, 4'b0000, 0, 1'b0);
    cyc();
    check_cycle("rstmid", 8, 4'b0000, 0, 1'b0);
    plain5("after_rst");

    // start held high with len=2: second accept in the IDLE cycle after done.
    bus.start = 1'b1;
    bus.len   = 8'd2;
    cyc();
    for (int k = 1; k <= 20; k++) begin
      int j, w;
      j = (k <= 10) ? k : k - 10;
      w = (k == 10) ? 0 : (j <= 5) ? 2 : (j == 6) ? 1 : 0;
      if (k == 11) bus.start = 1'b0;
      check_cycle("b2b", k, exp_state(j, 4, 6, 8), w, 1'b0);
      if (k < 20) cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_gate_seq.md
# sync_gate_seq

Sequencer that drives the Sync / Gate / Done control outputs for one transfer window. On a start request it issues a fixed-length Sync phase, opens the Gate for a programmed number of counted beats (pausable by hold), runs a fixed Drain phase, then pulses Done. Its one-hot state vector and word-count-zero flag feed the downstream Sync/Gate/Done decode logic.

## Interface
Parameters:
- CNT_W, 8, width of the beat length and word counter
- SYNC_CYCLES, 4, Sync phase length in cycles; must be at least 1
- DRAIN_CYCLES, 2, Drain phase length in cycles; 0 skips Drain

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  transfer request, sampled only in IDLE
- len  in  CNT_W  beat count, captured on an accepted start
- hold  in  1  pauses beat counting in GATE
- abort  in  1  terminates any active transfer
- sync  out  1  high throughout SYNC
- gate  out  1  high throughout GATE
- done  out  1  one-cycle pulse in DONE
- busy  out  1  state != IDLE
- state  out  4  one-hot: [0] SYNC, [1] GATE, [2] DRAIN, [3] DONE; all zero means IDLE
- wc  out  CNT_W  remaining beats
- wc0  out  1  wc == 0
- aborted  out  1  last transfer ended by abort; sticky until next accepted start

## Operation
- States: IDLE, SYNC, GATE, DRAIN, DONE. The state register is one-hot. sync, gate, done and busy decode directly from registered state (Moore), with no combinational path from inputs to outputs.
- IDLE, start=1, len!=0: capture wc<=len, clear aborted, load the phase counter with SYNC_CYCLES-1, go to SYNC.
- IDLE, start=1, len==0: clear aborted, go to DONE. No SYNC or GATE occurs and wc stays 0.
- SYNC: the phase counter decrements each cycle. At 0, go to GATE.
- GATE: on each cycle with hold=0, wc decrements. On the cycle where wc==1 and hold=0, wc becomes 0 and the block goes to DRAIN (loading DRAIN_CYCLES-1), or to DONE if DRAIN_CYCLES==0. With hold=1, wc and state are frozen and gate stays high.
- DRAIN: the phase counter decrements. At 0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- abort=1 in SYNC, GATE or DRAIN: next state is DONE, aborted<=1, wc frozen at its current value. abort in IDLE or DONE is ignored.
- Priority: rst > abort > hold > normal progression.
- start outside IDLE is ignored and not queued. This includes start in DONE.
- Arithmetic: wc is an unsigned CNT_W counter and never decrements below 0. len is taken modulo CNT_W width.

## Timing
- Reset: state=IDLE, sync=gate=done=busy=0, state=0000, wc=0, wc0=1, aborted=0, phase counter=0.
- Start accepted at cycle T:
  - sync is high for cycles T+1 .. T+SYNC_CYCLES.
  - gate is high from T+SYNC_CYCLES+1 for len + (number of hold cycles) cycles.
  - DRAIN follows for DRAIN_CYCLES cycles.
  - done pulses in the next cycle; IDLE is reached the cycle after done.
- Total latency with no hold, start to done: SYNC_CYCLES + len + DRAIN_CYCLES + 1 cycles.
- A new start is accepted earliest in the first IDLE cycle after done, giving back-to-back spacing of 1 idle cycle.
- abort at cycle A gives done at A+1 and IDLE at A+2.
- rst asserted mid-operation returns all outputs to reset values on the next edge. No done pulse is generated.

## Test plan
- SYNC_CYCLES=4, DRAIN_CYCLES=2, len=5, start at cycle 0 -> sync cycles 1–4, gate 5–9, wc 5→0 (wc0 at cycle 10), state 0100 at 10–11, done at 12, IDLE at 13, aborted=0.
- Same config, hold=1 at cycles 6–7 -> wc holds at 4 during cycles 6–7, gate high 5–11, done at 14.
- start with len=0 at cycle 0 -> done at cycle 1, no sync or gate ever asserted, wc0=1 throughout.
- len=5, abort at cycle 7 -> done at 8, aborted=1, wc frozen at 3, IDLE at 9. A new start at 9 clears aborted.
- len=5, rst at cycle 6 -> at cycle 7 all outputs at reset values, done never pulses. start at cycle 8 proceeds normally.
- start held high continuously, len=2 -> start is ignored while busy. The second transfer is accepted in the first IDLE cycle after done: sync rises 2 cycles after done.
